// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - 4-digit multiplexed seven-segment scan controller (optional SEG7_LZB_EN leading-zero blanking)
module seg7_scan_ctrl #(
    parameter int PRESCALE  = 1000,
    parameter int BLANK_CYC = 8,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] C,
    input  logic [3:0] D,
    input  logic       enable,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame
);

    typedef enum logic [1:0] {S_A = 2'd0, S_B = 2'd1, S_C = 2'd2, S_D = 2'd3} slot_e;

    slot_e             state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tick;
    logic              ready_q;
    logic              rdy_rise;
    logic              pend_q;
    logic [15:0]       pnd_q;
    logic [15:0]       disp_q;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        cur_digit;
    logic              cur_blank;

    function automatic logic [6:0] seg7_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    assign tick     = enable && (cnt_q == CNT_W'(PRESCALE - 1));
    assign rdy_rise = ready & ~ready_q;

    // Prescaler: counts clocks within a slot, held at zero while dark
    always_comb begin
        cnt_d = '0;
        if (enable && !tick) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Prescaler register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Slot FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot FSM next state: advance on tick, restart at slot A when disabled
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = S_A;
        end else if (tick) begin
            case (state_q)
                S_A:     state_d = S_B;
                S_B:     state_d = S_C;
                S_C:     state_d = S_D;
                default: state_d = S_A;
            endcase
        end
    end

    // Slot FSM outputs: frame boundary pulse and the digit shown in this slot
    always_comb begin
        frame     = tick && (state_q == S_D);
        cur_digit = 4'd0;
        cur_blank = 1'b0;
        case (state_q)
            S_A: begin
                cur_digit = disp_q[15:12];
`ifdef SEG7_LZB_EN
                cur_blank = (disp_q[15:12] == 4'd0);
`endif
            end
            S_B: begin
                cur_digit = disp_q[11:8];
`ifdef SEG7_LZB_EN
                cur_blank = (disp_q[15:8] == 8'd0);
`endif
            end
            S_C: begin
                cur_digit = disp_q[7:4];
`ifdef SEG7_LZB_EN
                cur_blank = (disp_q[15:4] == 12'd0);
`endif
            end
            default: begin
                cur_digit = disp_q[3:0];
                cur_blank = 1'b0;
            end
        endcase
    end

    // Next anode/segment drive from the current slot and blanking window
    always_comb begin
        an_d  = 4'hF;
        seg_d = 7'h7F;
        if (enable) begin
            if (cnt_q >= CNT_W'(BLANK_CYC)) begin
                case (state_q)
                    S_A:     an_d = 4'b0111;
                    S_B:     an_d = 4'b1011;
                    S_C:     an_d = 4'b1101;
                    default: an_d = 4'b1110;
                endcase
            end
            if (!cur_blank) begin
                seg_d = seg7_decode(cur_digit);
            end
        end
    end

    // Registered display outputs, one clock behind the scan position
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q  <= 4'hF;
            seg_q <= 7'h7F;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

    // Digit capture into pending regs; commit to displayed regs only at a frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
            pend_q  <= 1'b0;
            pnd_q   <= '0;
            disp_q  <= '0;
        end else begin
            ready_q <= ready;
            if (frame) begin
                if (rdy_rise) begin
                    disp_q <= {A, B, C, D};
                end else if (pend_q) begin
                    disp_q <= pnd_q;
                end
                pend_q <= 1'b0;
            end else if (rdy_rise) begin
                pnd_q  <= {A, B, C, D};
                pend_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - randomized self-checking bench for seg7_scan_ctrl against a frame-level model
module tb_seg7_scan_ctrl;

    localparam int P     = 4;
    localparam int BLANK = 1;
    localparam int FRAME = 4 * P;

    logic       clk = 1'b0;
    logic       rst, ready, enable;
    logic [3:0] A, B, C, D;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame;

    int n_vec  = 0;
    int n_miss = 0;

    // model state
    int         k;
    logic [3:0] disp [4];
    logic [3:0] pnd  [4];
    logic       pend;
    logic       rprev;
    logic       mdl_valid = 1'b0;
    logic [6:0] dec_tab [16];

    seg7_scan_ctrl #(.PRESCALE(P), .BLANK_CYC(BLANK), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .A(A), .B(B), .C(C), .D(D),
        .enable(enable), .an(an), .seg(seg), .frame(frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp_v);
        end
    endtask

    // One clock: inputs applied at negedge, frame checked before the edge, an/seg after it
    task automatic step();
        logic       exp_frame, rise, bnd, blank;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int         slot;
        #1;
        exp_frame = enable && (k == FRAME - 1);
        if (mdl_valid) chk("frame", {7'd0, frame}, {7'd0, exp_frame});
        slot = k / P;
        if (rst) begin
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
            k = 0; pend = 1'b0; rprev = 1'b0;
            for (int i = 0; i < 4; i++) begin disp[i] = 4'd0; pnd[i] = 4'd0; end
            mdl_valid = 1'b1;
        end else begin
            exp_an  = (!enable || (k % P) < BLANK) ? 4'hF : ~(4'b1000 >> slot);
            blank   = 1'b0;
`ifdef SEG7_LZB_EN
            if (slot < 3) begin
                blank = 1'b1;
                for (int i = 0; i <= slot; i++) if (disp[i] != 4'd0) blank = 1'b0;
            end
`endif
            exp_seg = (!enable || blank) ? 7'h7F : dec_tab[disp[slot]];
            rise = ready && !rprev;
            bnd  = exp_frame;
            if (bnd) begin
                if (rise) begin
                    disp[0] = A; disp[1] = B; disp[2] = C; disp[3] = D;
                end else if (pend) begin
                    for (int i = 0; i < 4; i++) disp[i] = pnd[i];
                end
                pend = 1'b0;
            end else if (rise) begin
                pnd[0] = A; pnd[1] = B; pnd[2] = C; pnd[3] = D;
                pend = 1'b1;
            end
            rprev = ready;
            k = enable ? (k + 1) % FRAME : 0;
        end
        @(posedge clk);
        #1;
        if (mdl_valid) begin
            chk("an", {4'd0, an}, {4'd0, exp_an});
            chk("seg", {1'b0, seg}, {1'b0, exp_seg});
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to_k(input int target);
        int guard = 0;
        while (k != target && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        chk("run_to_k", {7'd0, (k == target)}, 8'd1);
    endtask

    initial begin
        dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        k = 0; pend = 1'b0; rprev = 1'b0;
        for (int i = 0; i < 4; i++) begin disp[i] = 4'd0; pnd[i] = 4'd0; end
        rst = 1'b1; ready = 1'b0; enable = 1'b0;
        A = 4'd0; B = 4'd0; C = 4'd0; D = 4'd0;
        @(negedge clk);
        run(2);
        chk("rst_an", {4'd0, an}, 8'h0F);
        chk("rst_seg", {1'b0, seg}, 8'h7F);
        chk("rst_frame", {7'd0, frame}, 8'h00);

        // plain scan of zeros
        rst = 1'b0; enable = 1'b1;
        run(2 * FRAME);

        // capture mid-frame, shown from next frame
        run_to_k(5);
        A = 4'd1; B = 4'd2; C = 4'd3; D = 4'd4; ready = 1'b1;
        run(3);
        ready = 1'b0;
        run(2 * FRAME);

        // two captures in one frame, last wins
        run_to_k(2);
        A = 4'd1; B = 4'd2; C = 4'd3; D = 4'd4; ready = 1'b1; step(); ready = 1'b0; step();
        A = 4'd5; B = 4'd6; C = 4'd7; D = 4'd8; ready = 1'b1; step(); ready = 1'b0;
        run(2 * FRAME);

        // rising edge coincident with the frame boundary
        run_to_k(FRAME - 1);
        A = 4'd3; B = 4'd1; C = 4'd4; D = 4'd9; ready = 1'b1;
        step();
        ready = 1'b0;
        run(FRAME + 2);

        // dash in slot A, then disable mid-slot and re-enable
        run_to_k(FRAME - 1);
        A = 4'hC; ready = 1'b1; step(); ready = 1'b0;
        run(6);
        enable = 1'b0; run(5);
        enable = 1'b1; run(2 * FRAME);

        // leading-zero pattern 0,0,0,7
        run_to_k(FRAME - 1);
        A = 4'd0; B = 4'd0; C = 4'd0; D = 4'd7; ready = 1'b1; step(); ready = 1'b0;
        run(2 * FRAME);

        // reset mid-frame with a pending value
        run_to_k(6);
        A = 4'd9; B = 4'd9; C = 4'd9; D = 4'd9; ready = 1'b1; step(); ready = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        run(2 * FRAME);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                A = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                B = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                C = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                D = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 7) == 0) ready = ~ready;
            if (!enable) enable = ($urandom_range(0, 3) == 0);
            else         enable = ($urandom_range(0, 63) != 0);
            rst = ($urandom_range(0, 499) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
